// File: rtl/od_line_if.sv
// Pad-side bundle for od_line_monitor: raw readback, drive controls and the
// filtered/checked results, one bit per open-drain line.
interface od_line_if #(
  parameter int unsigned N = 1
) ();

  logic [N-1:0] rival_list;
  logic [N-1:0] rod_list;
  logic [N-1:0] roval_list;
  logic [N-1:0] conflict_clear;
  logic [N-1:0] filt_list;
  logic [N-1:0] rise_list;
  logic [N-1:0] fall_list;
  logic [N-1:0] conflict_list;

  // Bus engine / pad side: drives readback and drive controls, consumes results
  modport master (
    output rival_list,
    output rod_list,
    output roval_list,
    output conflict_clear,
    input  filt_list,
    input  rise_list,
    input  fall_list,
    input  conflict_list
  );

  // Monitor side
  modport slave (
    input  rival_list,
    input  rod_list,
    input  roval_list,
    input  conflict_clear,
    output filt_list,
    output rise_list,
    output fall_list,
    output conflict_list
  );

endinterface

// File: rtl/od_line_monitor.sv
// Receive/check companion for open-drain pads: per line it synchronises the
// raw readback, glitch-filters it, emits rise/fall pulses and flags a sticky
// conflict when the settled drive value is contradicted by the line level.
module od_line_monitor #(
  parameter int unsigned BW_DATA       = 1,
  parameter int unsigned NUM_DATA      = 1,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned BW_CNT        = $clog2(FILTER_CYCLES + 3)
) (
  input  logic       clk,
  input  logic       rst,
  od_line_if.slave   lines
);

  localparam int unsigned N          = BW_DATA * NUM_DATA;
  localparam int unsigned SETTLE_MAX = FILTER_CYCLES + 2;

  logic [N-1:0]        sync1;
  logic [N-1:0]        sync2;
  logic [N-1:0]        filt_q;
  logic [N-1:0]        rise_q;
  logic [N-1:0]        fall_q;
  logic [N-1:0]        conflict_q;
  logic [N-1:0]        prev_rod;
  logic [N-1:0]        prev_roval;
  logic [BW_CNT-1:0]   fcnt [N];
  logic [BW_CNT-1:0]   scnt [N];

  logic [N-1:0]        filt_next;
  logic [BW_CNT-1:0]   fcnt_next [N];
  logic [N-1:0]        settled;
  logic [N-1:0]        drive_restart;

  // Two-flop synchroniser, nothing between the stages
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= lines.rival_list;
      sync2 <= sync1;
    end
  end

  // Filter next-state: accept sync2 after FILTER_CYCLES consecutive disagreements
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      filt_next[i] = filt_q[i];
      fcnt_next[i] = '0;
      if (sync2[i] != filt_q[i]) begin
        if (fcnt[i] == BW_CNT'(FILTER_CYCLES - 1)) begin
          filt_next[i] = sync2[i];
        end else begin
          fcnt_next[i] = fcnt[i] + BW_CNT'(1);
        end
      end
    end
  end

  // Filter state and registered edge pulses aligned with the new level
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '1;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        fcnt[i] <= '0;
      end
    end else begin
      filt_q <= filt_next;
      rise_q <= filt_next & ~filt_q;
      fall_q <= ~filt_next & filt_q;
      for (int i = 0; i < int'(N); i++) begin
        fcnt[i] <= fcnt_next[i];
      end
    end
  end

  // Settle qualifiers: a drive is trusted once it has been stable long enough
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      settled[i]       = (scnt[i] == BW_CNT'(SETTLE_MAX));
      drive_restart[i] = lines.rod_list[i]
                       | (lines.rod_list[i]   != prev_rod[i])
                       | (lines.roval_list[i] != prev_roval[i]);
    end
  end

  // Settle counter and previous-drive history
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_rod   <= '1;
      prev_roval <= '1;
      for (int i = 0; i < int'(N); i++) begin
        scnt[i] <= '0;
      end
    end else begin
      prev_rod   <= lines.rod_list;
      prev_roval <= lines.roval_list;
      for (int i = 0; i < int'(N); i++) begin
        if (drive_restart[i]) begin
          scnt[i] <= '0;
        end else if (!settled[i]) begin
          scnt[i] <= scnt[i] + BW_CNT'(1);
        end
      end
    end
  end

  // Sticky conflict: set beats clear, never set while released
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (settled[i] && !lines.rod_list[i] &&
            (filt_q[i] != lines.roval_list[i])) begin
          conflict_q[i] <= 1'b1;
        end else if (lines.conflict_clear[i]) begin
          conflict_q[i] <= 1'b0;
        end
      end
    end
  end

  assign lines.filt_list     = filt_q;
  assign lines.rise_list     = rise_q;
  assign lines.fall_list     = fall_q;
  assign lines.conflict_list = conflict_q;

endmodule

// File: tb/tb_od_line_monitor.sv
// Randomised scoreboard bench for od_line_monitor with a per-line behavioural
// model; stimulus pushes expected outputs, a monitor pops and compares.
module tb_od_line_monitor;

  localparam int N  = 4;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst;

  od_line_if #(.N(N)) lif ();

  od_line_monitor #(
    .BW_DATA      (1),
    .NUM_DATA     (N),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .lines(lif)
  );

  always #5 clk = ~clk;

  // Scoreboard
  logic [4*N-1:0] expq [$];
  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state, one entry per line
  bit m_s1 [N];
  bit m_s2 [N];
  bit m_filt [N];
  bit m_rise [N];
  bit m_fall [N];
  bit m_conf [N];
  bit m_prod [N];
  bit m_proval [N];
  int m_run [N];   // consecutive edges sync2 has disagreed with filt
  int m_age [N];   // edges the current actively-driven value has been held

  task automatic model_step(input logic r, input logic [N-1:0] rv,
                            input logic [N-1:0] rd, input logic [N-1:0] ro,
                            input logic [N-1:0] cl);
    logic [N-1:0] ef, er, eff, ec;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_s1[i] = 1; m_s2[i] = 1; m_filt[i] = 1;
        m_rise[i] = 0; m_fall[i] = 0; m_conf[i] = 0;
        m_run[i] = 0; m_age[i] = 0;
        m_prod[i] = 1; m_proval[i] = 1;
      end else begin
        bit nf;
        bit is_settled;
        nf = m_filt[i];
        if (m_s2[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == FC) begin
            nf = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        is_settled = (m_age[i] >= FC + 2);
        if (!rd[i] && is_settled && (m_filt[i] != ro[i])) m_conf[i] = 1;
        else if (cl[i]) m_conf[i] = 0;
        if (rd[i] || (rd[i] != m_prod[i]) || (ro[i] != m_proval[i])) m_age[i] = 0;
        else if (m_age[i] < 1000) m_age[i]++;
        m_rise[i] = nf && !m_filt[i];
        m_fall[i] = !nf && m_filt[i];
        m_filt[i] = nf;
        m_s2[i] = m_s1[i];
        m_s1[i] = rv[i];
        m_prod[i] = rd[i];
        m_proval[i] = ro[i];
      end
      ef[i] = m_filt[i]; er[i] = m_rise[i]; eff[i] = m_fall[i]; ec[i] = m_conf[i];
    end
    expq.push_back({ef, er, eff, ec});
  endtask

  // Apply one cycle of stimulus and predict the outputs after the next edge
  task automatic apply(input logic r, input logic [N-1:0] rv,
                       input logic [N-1:0] rd, input logic [N-1:0] ro,
                       input logic [N-1:0] cl);
    @(negedge clk);
    rst                = r;
    lif.rival_list     = rv;
    lif.rod_list       = rd;
    lif.roval_list     = ro;
    lif.conflict_clear = cl;
    model_step(r, rv, rd, ro, cl);
  endtask

  // Monitor: outputs are valid every cycle, compare just after each edge
  initial begin
    logic [4*N-1:0] e;
    logic [4*N-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = {lif.filt_list, lif.rise_list, lif.fall_list, lif.conflict_list};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t outputs got filt=%b rise=%b fall=%b conf=%b exp filt=%b rise=%b fall=%b conf=%b",
                   vectors, $time, got[4*N-1:3*N], got[3*N-1:2*N], got[2*N-1:N], got[N-1:0],
                   e[4*N-1:3*N], e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [N-1:0] ext, rod, roval, pad, clr;
    int ehold [N];
    int dhold [N];
    rst = 1'b1;
    lif.rival_list = '1; lif.rod_list = '1; lif.roval_list = '1; lif.conflict_clear = '0;

    repeat (3) apply(1'b1, '1, '1, '1, '0);
    repeat (4) apply(1'b0, '1, '1, '1, '0);

    // Line 0: 2-cycle low glitch, then a 3-cycle low that must pass
    repeat (2) apply(1'b0, 4'b1110, '1, '1, '0);
    repeat (8) apply(1'b0, '1, '1, '1, '0);
    repeat (3) apply(1'b0, 4'b1110, '1, '1, '0);
    repeat (10) apply(1'b0, '1, '1, '1, '0);

    // Line 2 drives 1 but the pad is held low; clear while mismatch persists
    repeat (10) apply(1'b0, 4'b1011, 4'b1011, '1, '0);
    repeat (2) apply(1'b0, 4'b1011, 4'b1011, '1, 4'b0100);
    repeat (3) apply(1'b0, 4'b1011, 4'b1011, '1, '0);
    repeat (2) apply(1'b0, '1, '1, '1, 4'b0100);

    // Line 1 driven low with pad following, toggling every 2 cycles
    for (int k = 0; k < 12; k++) begin
      logic [N-1:0] v;
      v = (k % 4 < 2) ? 4'b1101 : 4'b1111;
      apply(1'b0, v, 4'b1101, v, '0);
    end

    // Released line held low never flags, then mid-run reset with filt low
    repeat (12) apply(1'b0, 4'b0000, '1, '1, '0);
    apply(1'b1, 4'b0000, '1, '1, '0);
    repeat (4) apply(1'b0, '1, '1, '1, '0);

    // Randomised traffic with wired-AND pads and occasional faults/resets
    ext = '1; rod = '1; roval = '1;
    for (int i = 0; i < N; i++) begin
      ehold[i] = 0;
      dhold[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ehold[i] == 0) begin
          ext[i] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
          ehold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 12);
        end else begin
          ehold[i]--;
        end
        if (dhold[i] == 0) begin
          rod[i]   = ($urandom_range(0, 2) == 0);
          roval[i] = $urandom_range(0, 1) != 0;
          dhold[i] = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 16);
        end else begin
          dhold[i]--;
        end
        pad[i] = ext[i] & (rod[i] ? 1'b1 : roval[i]);
        if ($urandom_range(0, 40) == 0) pad[i] = ~pad[i];
        clr[i] = ($urandom_range(0, 5) == 0);
      end
      apply(($urandom_range(0, 299) == 0), pad, rod, roval, clr);
    end

    @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
